// File: rtl/regfile_pkg.sv
// Shared definitions for the general-purpose register file: size defaults,
// branch-port FSM states and write-source select encodings.
package regfile_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 8;

    typedef enum logic {
        BR_IDLE = 1'b0,
        BR_WAIT = 1'b1
    } br_state_e;

    localparam logic WSEL_ALU = 1'b1;
    localparam logic WSEL_ID  = 1'b0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set by reserve, cleared
// by writeback, with per-read-port and branch-port busy lookups.
module regfile_scoreboard #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_RD   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     set_i,
    input  logic [ADDR_W-1:0]        set_addr_i,
    input  logic                     clr_i,
    input  logic [ADDR_W-1:0]        clr_addr_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    input  logic [NUM_RD-1:0]        rd_hit_i,
    input  logic [ADDR_W-1:0]        br_addr_i,
    output logic [NUM_RD-1:0]        rd_busy_c,
    output logic                     br_pend_c
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // A reserve in the same cycle as a writeback wins: the new producer is in flight.
    always_comb begin
        pending_d = pending_q;
        if (clr_i) pending_d[clr_addr_i] = 1'b0;
        if (set_i) pending_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
        assign rd_busy_c[i] = pending_q[rd_addr_i[i*ADDR_W +: ADDR_W]] & ~rd_hit_i[i];
    end

    assign br_pend_c = pending_q[br_addr_i];

endmodule

// File: rtl/gp_regfile.sv
// Parametrised register file with write-to-read bypass, pending scoreboard
// and a handshaked branch-target read port that waits on pending producers.
module gp_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     wr_sel,
    input  logic [DATA_W-1:0]        wr_data_alu,
    input  logic [DATA_W-1:0]        wr_data_id,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     br_req,
    input  logic [ADDR_W-1:0]        br_addr,
    output logic                     br_ready,
    output logic                     br_valid,
    output logic [DATA_W-1:0]        br_value
);

    logic [DATA_W-1:0] wdata_c;
    logic              wr_ok_c;
    logic              rsv_ok_c;
    logic [NUM_RD-1:0] rd_hit_c;
    logic              br_pend_c;
    logic              br_hit_c;

    assign wdata_c  = (wr_sel == WSEL_ALU) ? wr_data_alu : wr_data_id;
    assign wr_ok_c  = wr_en  && !(ZERO_REG && (wr_addr  == '0));
    assign rsv_ok_c = rsv_en && !(ZERO_REG && (rsv_addr == '0));

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (wr_ok_c) begin
            regs_q[wr_addr] <= wdata_c;
        end
    end

    // Register 0 never stores under ZERO_REG, so storage alone returns 0 for it.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] addr_c;
        assign addr_c      = rd_addr[i*ADDR_W +: ADDR_W];
        assign rd_hit_c[i] = BYPASS && wr_ok_c && (wr_addr == addr_c);
        assign rd_data[i*DATA_W +: DATA_W] = rd_hit_c[i] ? wdata_c : regs_q[addr_c];
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD)
    ) u_sb (
        .clk        (clk),
        .rst_n      (reset),
        .set_i      (rsv_ok_c),
        .set_addr_i (rsv_addr),
        .clr_i      (wr_ok_c),
        .clr_addr_i (wr_addr),
        .rd_addr_i  (rd_addr),
        .rd_hit_i   (rd_hit_c),
        .br_addr_i  (br_addr),
        .rd_busy_c  (rd_busy),
        .br_pend_c  (br_pend_c)
    );

    br_state_e         state_q,  state_d;
    logic [ADDR_W-1:0] baddr_q,  baddr_d;
    logic [DATA_W-1:0] bvalue_q, bvalue_d;
    logic              bvalid_q, bvalid_d;
    logic              bready_q, bready_d;

    assign br_hit_c = wr_ok_c && (wr_addr == br_addr);

    // Branch port: resolve immediately when the target is ready, else park in WAIT.
    always_comb begin
        state_d  = state_q;
        baddr_d  = baddr_q;
        bvalue_d = bvalue_q;
        bvalid_d = 1'b0;
        unique case (state_q)
            BR_IDLE: begin
                if (br_req) begin
                    if (!br_pend_c || br_hit_c) begin
                        bvalue_d = br_hit_c ? wdata_c : regs_q[br_addr];
                        bvalid_d = 1'b1;
                    end else begin
                        baddr_d = br_addr;
                        state_d = BR_WAIT;
                    end
                end
            end
            BR_WAIT: begin
                if (wr_ok_c && (wr_addr == baddr_q)) begin
                    bvalue_d = wdata_c;
                    bvalid_d = 1'b1;
                    state_d  = BR_IDLE;
                end
            end
            default: state_d = BR_IDLE;
        endcase
        bready_d = (state_d == BR_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= BR_IDLE;
            baddr_q  <= '0;
            bvalue_q <= '0;
            bvalid_q <= 1'b0;
            bready_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            baddr_q  <= baddr_d;
            bvalue_q <= bvalue_d;
            bvalid_q <= bvalid_d;
            bready_q <= bready_d;
        end
    end

    assign br_ready = bready_q;
    assign br_valid = bvalid_q;
    assign br_value = bvalue_q;

endmodule

// File: tb/tb_gp_regfile.sv
// Bench for gp_regfile: two instances (ZERO_REG=0 and 1) share stimulus and are
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_gp_regfile;

    logic        clk;
    logic        reset;
    logic [5:0]  rd_addr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic        wr_sel;
    logic [31:0] wr_data_alu;
    logic [31:0] wr_data_id;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic        br_req;
    logic [2:0]  br_addr;

    logic [63:0] rd_data_o  [2];
    logic [1:0]  rd_busy_o  [2];
    logic        br_ready_o [2];
    logic        br_valid_o [2];
    logic [31:0] br_value_o [2];

    int n_cmp  = 0;
    int n_fail = 0;
    bit started = 1'b0;

    gp_regfile #(.ZERO_REG(1'b0)) dut0 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_o[0]),
        .rd_busy(rd_busy_o[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_data_alu(wr_data_alu), .wr_data_id(wr_data_id), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .br_req(br_req), .br_addr(br_addr),
        .br_ready(br_ready_o[0]), .br_valid(br_valid_o[0]), .br_value(br_value_o[0])
    );

    gp_regfile #(.ZERO_REG(1'b1)) dut1 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_o[1]),
        .rd_busy(rd_busy_o[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_sel(wr_sel),
        .wr_data_alu(wr_data_alu), .wr_data_id(wr_data_id), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .br_req(br_req), .br_addr(br_addr),
        .br_ready(br_ready_o[1]), .br_valid(br_valid_o[1]), .br_value(br_value_o[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: register array, pending set, and a waiting-branch slot.
    logic [31:0] m_reg  [2][8];
    logic        m_pend [2][8];
    logic        m_wait [2];
    logic [2:0]  m_waddr[2];
    logic [31:0] m_val  [2];
    logic        m_vld  [2];

    function automatic logic [31:0] m_wd();
        return wr_sel ? wr_data_alu : wr_data_id;
    endfunction

    function automatic logic m_wok(int k);
        return wr_en && !(k == 1 && wr_addr == 3'd0);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 8; r++) begin
                    m_reg[k][r]  = 32'd0;
                    m_pend[k][r] = 1'b0;
                end
                m_wait[k] = 1'b0; m_waddr[k] = 3'd0; m_val[k] = 32'd0; m_vld[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic wok, rok, hit;
                wok = m_wok(k);
                rok = rsv_en && !(k == 1 && rsv_addr == 3'd0);
                m_vld[k] = 1'b0;
                if (!m_wait[k]) begin
                    if (br_req) begin
                        hit = wok && (wr_addr == br_addr);
                        if (!m_pend[k][br_addr] || hit) begin
                            m_val[k] = hit ? m_wd() : m_reg[k][br_addr];
                            m_vld[k] = 1'b1;
                        end else begin
                            m_wait[k]  = 1'b1;
                            m_waddr[k] = br_addr;
                        end
                    end
                end else if (wok && wr_addr == m_waddr[k]) begin
                    m_val[k]  = m_wd();
                    m_vld[k]  = 1'b1;
                    m_wait[k] = 1'b0;
                end
                if (wok) begin
                    m_reg[k][wr_addr]  = m_wd();
                    m_pend[k][wr_addr] = 1'b0;
                end
                if (rok) m_pend[k][rsv_addr] = 1'b1;
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                for (int p = 0; p < 2; p++) begin
                    logic [2:0] a;
                    logic       hit;
                    a   = rd_addr[p*3 +: 3];
                    hit = m_wok(k) && (wr_addr == a);
                    chk($sformatf("inst%0d rd_data p%0d", k, p), 64'(rd_data_o[k][p*32 +: 32]),
                        64'(hit ? m_wd() : m_reg[k][a]));
                    chk($sformatf("inst%0d rd_busy p%0d", k, p), 64'(rd_busy_o[k][p]),
                        64'(m_pend[k][a] && !hit));
                end
                chk($sformatf("inst%0d br_ready", k), 64'(br_ready_o[k]), 64'(!m_wait[k]));
                chk($sformatf("inst%0d br_valid", k), 64'(br_valid_o[k]), 64'(m_vld[k]));
                chk($sformatf("inst%0d br_value", k), 64'(br_value_o[k]), 64'(m_val[k]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_sel = 1'b0;
        wr_data_alu = '0; wr_data_id = '0; rsv_en = 1'b0; rsv_addr = '0;
        br_req = 1'b0; br_addr = '0;
        @(posedge clk);
        started = 1'b1;
        step(); #1;
        chk("reset br_ready", 64'(br_ready_o[0]), 64'd1);
        chk("reset br_valid", 64'(br_valid_o[0]), 64'd0);
        chk("reset br_value", 64'(br_value_o[0]), 64'd0);
        chk("reset rd_data", rd_data_o[0], 64'd0);
        reset = 1'b1;

        // Bypass then storage read of 0xDEADBEEF in r3.
        step(); wr_en = 1'b1; wr_addr = 3'd3; wr_sel = 1'b1; wr_data_alu = 32'hDEADBEEF;
        rd_addr = {3'd0, 3'd3}; #1;
        chk("bypass r3", 64'(rd_data_o[0][31:0]), 64'hDEADBEEF);
        step(); wr_en = 1'b0; #1;
        chk("stored r3", 64'(rd_data_o[0][31:0]), 64'hDEADBEEF);

        // Zero register: write and reserve to address 0.
        step(); wr_en = 1'b1; wr_addr = 3'd0; wr_data_alu = 32'h1234; rd_addr = {3'd0, 3'd3}; #1;
        chk("zr write bypass blocked", 64'(rd_data_o[1][63:32]), 64'd0);
        chk("nzr write bypass", 64'(rd_data_o[0][63:32]), 64'h1234);
        step(); wr_en = 1'b0; rsv_en = 1'b1; rsv_addr = 3'd0; #1;
        chk("zr read r0", 64'(rd_data_o[1][63:32]), 64'd0);
        step(); rsv_en = 1'b0; #1;
        chk("zr busy r0", 64'(rd_busy_o[1][1]), 64'd0);
        chk("nzr busy r0", 64'(rd_busy_o[0][1]), 64'd1);

        // Scoreboard on r5.
        step(); rsv_en = 1'b1; rsv_addr = 3'd5; rd_addr = {3'd0, 3'd5}; #1;
        chk("r5 busy before edge", 64'(rd_busy_o[0][0]), 64'd0);
        step(); rsv_en = 1'b0; #1;
        chk("r5 busy reserved", 64'(rd_busy_o[0][0]), 64'd1);
        wr_en = 1'b1; wr_addr = 3'd5; wr_sel = 1'b0; wr_data_id = 32'h55; #1;
        chk("r5 busy drops on write", 64'(rd_busy_o[0][0]), 64'd0);
        chk("r5 bypass id data", 64'(rd_data_o[0][31:0]), 64'h55);
        step(); wr_en = 1'b0; #1;
        chk("r5 pending cleared", 64'(rd_busy_o[0][0]), 64'd0);
        step(); rsv_en = 1'b1; rsv_addr = 3'd5; wr_en = 1'b1; wr_addr = 3'd5; wr_data_id = 32'h66; #1;
        step(); rsv_en = 1'b0; wr_en = 1'b0; #1;
        chk("r5 rsv wins over write", 64'(rd_busy_o[0][0]), 64'd1);
        chk("r5 write still stored", 64'(rd_data_o[0][31:0]), 64'h66);

        // Branch on a ready register.
        step(); wr_en = 1'b1; wr_addr = 3'd2; wr_sel = 1'b1; wr_data_alu = 32'hA0;
        step(); wr_en = 1'b0; br_req = 1'b1; br_addr = 3'd2;
        step(); br_req = 1'b0; #1;
        chk("br r2 valid", 64'(br_valid_o[0]), 64'd1);
        chk("br r2 value", 64'(br_value_o[0]), 64'hA0);
        chk("br r2 ready", 64'(br_ready_o[0]), 64'd1);
        step(); #1;
        chk("br valid one pulse", 64'(br_valid_o[0]), 64'd0);

        // Branch waiting on pending r6; request during WAIT is dropped.
        step(); rsv_en = 1'b1; rsv_addr = 3'd6;
        step(); rsv_en = 1'b0; br_req = 1'b1; br_addr = 3'd6;
        step(); br_req = 1'b0; #1;
        chk("wait ready c1", 64'(br_ready_o[0]), 64'd0);
        step(); br_req = 1'b1; br_addr = 3'd2; #1;
        chk("wait ready c2", 64'(br_ready_o[0]), 64'd0);
        step(); br_req = 1'b0; wr_en = 1'b1; wr_addr = 3'd6; wr_data_alu = 32'h400; #1;
        chk("wait ready c3", 64'(br_ready_o[0]), 64'd0);
        step(); wr_en = 1'b0; #1;
        chk("wait resolve valid", 64'(br_valid_o[0]), 64'd1);
        chk("wait resolve value", 64'(br_value_o[0]), 64'h400);
        chk("wait resolve ready", 64'(br_ready_o[0]), 64'd1);
        step(); #1;
        chk("wait req dropped", 64'(br_value_o[0]), 64'h400);

        // Reset abandons an in-flight WAIT.
        step(); rsv_en = 1'b1; rsv_addr = 3'd7;
        step(); rsv_en = 1'b0; br_req = 1'b1; br_addr = 3'd7;
        step(); br_req = 1'b0; rd_addr = {3'd6, 3'd3}; #1;
        chk("pre-reset waiting", 64'(br_ready_o[0]), 64'd0);
        step(); reset = 1'b0; #1;
        chk("mid-wait reset ready", 64'(br_ready_o[0]), 64'd1);
        chk("mid-wait reset value", 64'(br_value_o[0]), 64'd0);
        chk("mid-wait reset regs", rd_data_o[0], 64'd0);
        step(); step(); reset = 1'b1;
        step(); wr_en = 1'b1; wr_addr = 3'd7; wr_data_alu = 32'h99;
        step(); wr_en = 1'b0; #1;
        chk("no valid after reset", 64'(br_valid_o[0]), 64'd0);
        step(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
